// File: rtl/snax_simbacore_csr_initiator.sv
// CSR request initiator for SimbaCore: writes a packed job config, polls status until idle,
// then reads the result. Optional poll timeout: SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN.
module snax_simbacore_csr_initiator #(
    parameter int unsigned NumRwCsr      = 5,
    parameter int unsigned NumRoCsr      = 2,
    parameter logic [31:0] CsrBaseAddr   = 32'h3c0,
    parameter int unsigned PollGap       = 4,
    parameter int unsigned StatusBit     = 0,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumRwCsr*32-1:0]  cfg_data_i,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    output logic [31:0]             done_data_o,
    output logic                    done_valid_o,
    input  logic                    done_ready_i,
    output logic [31:0]             csr_req_data_o,
    output logic [31:0]             csr_req_addr_o,
    output logic                    csr_req_write_o,
    output logic                    csr_req_valid_o,
    input  logic                    csr_req_ready_i,
    input  logic [31:0]             csr_rsp_data_i,
    input  logic                    csr_rsp_valid_i,
    output logic                    csr_rsp_ready_o,
`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
    output logic                    timeout_o,
`endif
    output logic                    busy_o
);

    localparam int unsigned IdxW = (NumRwCsr > 1) ? $clog2(NumRwCsr) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRwCsr - 1);

    if (NumRoCsr < 2 || PollGap < 1 || TimeoutCycles < 1) begin : g_bad_param
        $error("snax_simbacore_csr_initiator: illegal parameter value");
    end

    typedef enum logic [2:0] {
        StIdle, StWrite, StGap, StPollReq, StPollRsp, StResReq, StResRsp, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [31:0]       gap_q, gap_d;
    logic [31:0]       rw_q [NumRwCsr];
    logic              load_cfg;
    logic              req_valid_q, req_valid_d;
    logic              req_write_q, req_write_d;
    logic [31:0]       req_addr_q, req_addr_d;
    logic [31:0]       req_data_q, req_data_d;
    logic [31:0]       done_data_q, done_data_d;
`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
    logic [31:0]       to_cnt_q, to_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        load_cfg    = 1'b0;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        done_data_d = done_data_q;
`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        timeout_d   = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cfg_valid_i) begin
                    state_d     = StWrite;
                    idx_d       = '0;
                    load_cfg    = 1'b1;
                    req_valid_d = 1'b1;
                    req_write_d = 1'b1;
                    req_addr_d  = CsrBaseAddr;
                    req_data_d  = cfg_data_i[31:0];
                end
            end
            StWrite: begin
                if (csr_req_ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d     = StGap;
                        gap_d       = '0;
                        req_valid_d = 1'b0;
                        req_write_d = 1'b0;
                        req_data_d  = '0;
`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
                        to_cnt_d    = '0;
`endif
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        req_addr_d = CsrBaseAddr + 32'(idx_q) + 32'd1;
                        req_data_d = rw_q[idx_q + 1'b1];
                    end
                end
            end
            StGap: begin
`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
                if (to_cnt_q >= TimeoutCycles) begin
                    state_d     = StDone;
                    done_data_d = 32'hDEAD_0001;
                    timeout_d   = 1'b1;
                end else
`endif
                if (gap_q == PollGap - 1) begin
                    state_d     = StPollReq;
                    req_valid_d = 1'b1;
                    req_write_d = 1'b0;
                    req_addr_d  = CsrBaseAddr + NumRwCsr;
                    req_data_d  = '0;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            StPollReq: begin
                if (csr_req_ready_i) begin
                    state_d     = StPollRsp;
                    req_valid_d = 1'b0;
                end
            end
            StPollRsp: begin
                if (csr_rsp_valid_i) begin
                    if (csr_rsp_data_i[StatusBit]) begin
                        state_d = StGap;
                        gap_d   = '0;
                    end else begin
                        state_d     = StResReq;
                        req_valid_d = 1'b1;
                        req_addr_d  = CsrBaseAddr + NumRwCsr + 32'd1;
                    end
                end
            end
            StResReq: begin
                if (csr_req_ready_i) begin
                    state_d     = StResRsp;
                    req_valid_d = 1'b0;
                end
            end
            StResRsp: begin
                if (csr_rsp_valid_i) begin
                    state_d     = StDone;
                    done_data_d = csr_rsp_data_i;
                end
            end
            StDone: begin
                if (done_ready_i) begin
                    state_d = StIdle;
`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
        // Saturating budget counter for the whole polling loop
        if ((state_q == StGap || state_q == StPollReq || state_q == StPollRsp) &&
            to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + 32'd1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            gap_q       <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            done_data_q <= '0;
            for (int i = 0; i < NumRwCsr; i++) rw_q[i] <= '0;
`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            done_data_q <= done_data_d;
            if (load_cfg) begin
                for (int i = 0; i < NumRwCsr; i++) rw_q[i] <= cfg_data_i[32*i +: 32];
            end
`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign cfg_ready_o     = (state_q == StIdle);
    assign busy_o          = (state_q != StIdle);
    assign done_valid_o    = (state_q == StDone);
    assign done_data_o     = done_data_q;
    assign csr_rsp_ready_o = (state_q == StPollRsp) || (state_q == StResRsp);
    assign csr_req_valid_o = req_valid_q;
    assign csr_req_write_o = req_write_q;
    assign csr_req_addr_o  = req_addr_q;
    assign csr_req_data_o  = req_data_q;
`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
    assign timeout_o       = timeout_q;
`endif

endmodule
